// File: rtl/risc_lsu.sv
`default_nettype none
// ============================================================================
//  Module   : risc_lsu
//  Purpose  : RV32I memory-stage load/store unit. Accepts one access per
//             handshake, runs a single-outstanding req/gnt/rvalid transfer on
//             the data-memory port, and returns extended load data or a store
//             completion. Flags misaligned/illegal accesses and timeouts.
//  Ports    : clk, rst                      - clock, sync active-high reset
//             in_*  (valid/ready)           - access from execute
//             mem_* (req/gnt/rvalid)        - data-memory port
//             out_* (valid/ready)           - result to writeback
//  Revision : 1.0 - initial release
// ============================================================================
module risc_lsu #(
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic        in_is_store,
   input  logic [31:0] in_addr,
   input  logic [31:0] in_wdata,
   input  logic [1:0]  in_size,
   input  logic        in_unsigned,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [3:0]  mem_be,
   output logic [31:0] mem_wdata,
   input  logic        mem_gnt,
   input  logic        mem_rvalid,
   input  logic [31:0] mem_rdata,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_rdata,
   output logic        out_err,
   output logic        out_err_timeout
);

   localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2,
      S_RESP = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             is_store_q, is_store_d;
   logic [31:0]      addr_q, addr_d;
   logic [1:0]       size_q, size_d;
   logic             uns_q, uns_d;
   logic [3:0]       be_q, be_d;
   logic [31:0]      wdata_q, wdata_d;
   logic [31:0]      rdata_q, rdata_d;
   logic             err_q, err_d;
   logic             err_to_q, err_to_d;

   // Decode of the incoming access, used only at accept time.
   logic        misal;
   logic [3:0]  be_in;
   logic [31:0] wdata_in;

   always_comb begin
      misal    = 1'b0;
      be_in    = 4'b1111;
      wdata_in = in_wdata;
      case (in_size)
         2'b00: begin
            be_in    = 4'b0001 << in_addr[1:0];
            wdata_in = {4{in_wdata[7:0]}};
         end
         2'b01: begin
            misal    = in_addr[0];
            be_in    = in_addr[1] ? 4'b1100 : 4'b0011;
            wdata_in = {2{in_wdata[15:0]}};
         end
         2'b11: misal = (in_addr[1:0] != 2'b00);
         default: misal = 1'b1;
      endcase
   end

   // Load lane extraction: shift the addressed byte/half down to bit 0,
   // then extend according to size and signedness.
   logic [31:0] lane;
   logic [31:0] ld_ext;

   always_comb begin
      lane   = mem_rdata >> {addr_q[1:0], 3'b000};
      ld_ext = mem_rdata;
      case (size_q)
         2'b00: ld_ext = {{24{~uns_q & lane[7]}},  lane[7:0]};
         2'b01: ld_ext = {{16{~uns_q & lane[15]}}, lane[15:0]};
         default: ld_ext = mem_rdata;
      endcase
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      is_store_d = is_store_q;
      addr_d     = addr_q;
      size_d     = size_q;
      uns_d      = uns_q;
      be_d       = be_q;
      wdata_d    = wdata_q;
      rdata_d    = rdata_q;
      err_d      = err_q;
      err_to_d   = err_to_q;
      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               is_store_d = in_is_store;
               addr_d     = in_addr;
               size_d     = in_size;
               uns_d      = in_unsigned;
               be_d       = be_in;
               wdata_d    = wdata_in;
               rdata_d    = 32'd0;
               err_d      = misal;
               err_to_d   = 1'b0;
               cnt_d      = '0;
               state_d    = misal ? S_RESP : S_REQ;
            end
         end
         S_REQ: begin
            if (mem_gnt) begin
               cnt_d   = '0;
               state_d = is_store_q ? S_RESP : S_WAIT;
            end else if (cnt_q == CNT_LAST) begin
               cnt_d    = '0;
               err_d    = 1'b1;
               err_to_d = 1'b1;
               state_d  = S_RESP;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_WAIT: begin
            if (mem_rvalid) begin
               cnt_d   = '0;
               rdata_d = ld_ext;
               state_d = S_RESP;
            end else if (cnt_q == CNT_LAST) begin
               cnt_d    = '0;
               err_d    = 1'b1;
               err_to_d = 1'b1;
               state_d  = S_RESP;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_RESP: begin
            if (out_ready) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         is_store_q <= 1'b0;
         addr_q     <= 32'd0;
         size_q     <= 2'b00;
         uns_q      <= 1'b0;
         be_q       <= 4'd0;
         wdata_q    <= 32'd0;
         rdata_q    <= 32'd0;
         err_q      <= 1'b0;
         err_to_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         is_store_q <= is_store_d;
         addr_q     <= addr_d;
         size_q     <= size_d;
         uns_q      <= uns_d;
         be_q       <= be_d;
         wdata_q    <= wdata_d;
         rdata_q    <= rdata_d;
         err_q      <= err_d;
         err_to_q   <= err_to_d;
      end
   end

   // Memory payload is driven only while requesting so the port is quiet
   // (all zero) in every other state.
   assign in_ready        = (state_q == S_IDLE);
   assign mem_req         = (state_q == S_REQ);
   assign mem_we          = mem_req & is_store_q;
   assign mem_addr        = mem_req ? {addr_q[31:2], 2'b00} : 32'd0;
   assign mem_be          = mem_req ? be_q : 4'd0;
   assign mem_wdata       = mem_req ? wdata_q : 32'd0;
   assign out_valid       = (state_q == S_RESP);
   assign out_rdata       = out_valid ? rdata_q : 32'd0;
   assign out_err         = out_valid & err_q;
   assign out_err_timeout = out_valid & err_to_q;

endmodule
`default_nettype wire

// File: tb/tb_risc_lsu.sv
`default_nettype none
// ============================================================================
//  Module   : tb_risc_lsu
//  Purpose  : Self-checking bench for risc_lsu: directed vector table,
//             hand-written reset/stray-response sequences, and randomized
//             accesses checked against a byte-lane reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_risc_lsu;

   localparam int TMO   = 16;
   localparam int NEVER = 1000;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid, in_ready, in_is_store, in_unsigned;
   logic [31:0] in_addr, in_wdata;
   logic [1:0]  in_size;
   logic        mem_req, mem_we, mem_gnt, mem_rvalid;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic [3:0]  mem_be;
   logic        out_valid, out_ready, out_err, out_err_timeout;
   logic [31:0] out_rdata;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   risc_lsu #(.TIMEOUT_CYCLES(TMO)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_is_store(in_is_store),
      .in_addr(in_addr), .in_wdata(in_wdata), .in_size(in_size),
      .in_unsigned(in_unsigned),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_gnt(mem_gnt),
      .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
      .out_valid(out_valid), .out_ready(out_ready), .out_rdata(out_rdata),
      .out_err(out_err), .out_err_timeout(out_err_timeout)
   );

   typedef struct {
      logic        st;
      logic [31:0] a;
      logic [31:0] wd;
      logic [1:0]  sz;
      logic        uns;
      int          gd;
      int          rvd;
      int          rdyd;
      logic [31:0] rd;
      logic [3:0]  be;
      logic [31:0] mwd;
      logic [31:0] exp_rd;
      logic        exp_err;
      logic        exp_to;
   } vec_t;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // ---------------- reference model (byte-lane arithmetic) ----------------
   function automatic int nbytes(input logic [1:0] sz);
      return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
   endfunction

   function automatic logic is_misaligned(input logic [31:0] a, input logic [1:0] sz);
      if (sz == 2'b10) return 1'b1;
      return (a % nbytes(sz)) != 0;
   endfunction

   function automatic logic [3:0] model_be(input logic [31:0] a, input logic [1:0] sz);
      int v;
      v = ((1 << nbytes(sz)) - 1) << (a % 4);
      return v[3:0];
   endfunction

   function automatic logic [31:0] model_wdata(input logic [31:0] wd, input logic [1:0] sz);
      int          nb;
      logic [63:0] unit;
      logic [31:0] r;
      nb   = nbytes(sz);
      unit = (64'd1 << (8 * nb)) - 1;
      unit = unit & {32'd0, wd};
      r    = 32'd0;
      for (int i = 0; i < 4 / nb; i++) r = r | 32'(unit << (8 * nb * i));
      return r;
   endfunction

   function automatic logic [31:0] model_load(input logic [31:0] rd, input logic [31:0] a,
                                              input logic [1:0] sz, input logic uns);
      int          nb;
      logic [31:0] v;
      logic [31:0] m;
      nb = nbytes(sz);
      if (nb == 4) return rd;
      v = rd >> (8 * (a % 4));
      m = (32'd1 << (8 * nb)) - 1;
      v = v & m;
      if (!uns && v[8 * nb - 1]) v = v | ~m;
      return v;
   endfunction

   // ---------------- one complete access with cycle-level checks ----------------
   task automatic run_access(input vec_t v);
      int   n;
      logic granted;
      chk("in_ready_idle", in_ready, 1);
      in_valid    = 1'b1;
      in_is_store = v.st;
      in_addr     = v.a;
      in_wdata    = v.wd;
      in_size     = v.sz;
      in_unsigned = v.uns;
      @(negedge clk);
      in_valid = 1'b0;
      in_addr  = $urandom;
      in_wdata = $urandom;
      in_size  = 2'($urandom);
      granted  = 1'b0;
      if (v.exp_err && !v.exp_to) begin
         chk("mis_no_req", mem_req, 0);
      end else begin
         n = 0;
         forever begin
            chk("req_mem_req", mem_req, 1);
            chk("req_we", mem_we, v.st);
            chk("req_addr", mem_addr, {v.a[31:2], 2'b00});
            chk("req_be", mem_be, v.be);
            if (v.st) chk("req_wdata", mem_wdata, v.mwd);
            chk("req_out_valid", out_valid, 0);
            chk("req_in_ready", in_ready, 0);
            mem_gnt = (n == v.gd);
            @(negedge clk);
            mem_gnt = 1'b0;
            if (n == v.gd) begin
               granted = 1'b1;
               break;
            end
            n++;
            if (n >= TMO) break;
         end
         if (granted && !v.st) begin
            n = 0;
            forever begin
               chk("wait_mem_req", mem_req, 0);
               chk("wait_out_valid", out_valid, 0);
               mem_rvalid = (n == v.rvd);
               mem_rdata  = (n == v.rvd) ? v.rd : $urandom;
               @(negedge clk);
               mem_rvalid = 1'b0;
               mem_rdata  = $urandom;
               if (n == v.rvd) break;
               n++;
               if (n >= TMO) break;
            end
         end
      end
      for (int k = 0; k <= v.rdyd; k++) begin
         chk("resp_out_valid", out_valid, 1);
         chk("resp_out_rdata", out_rdata, v.exp_rd);
         chk("resp_out_err", out_err, v.exp_err);
         chk("resp_out_err_timeout", out_err_timeout, v.exp_to);
         chk("resp_in_ready", in_ready, 0);
         chk("resp_mem_req", mem_req, 0);
         out_ready = (k == v.rdyd);
         @(negedge clk);
         out_ready = 1'b0;
      end
      chk("post_out_valid", out_valid, 0);
      chk("post_in_ready", in_ready, 1);
   endtask

   vec_t tbl[12];
   vec_t rv;

   initial begin
      //          st    addr          wdata         sz     uns   gd     rvd    rdy rdata         be       mem_wdata     exp_rdata     err   to
      tbl[0]  = '{1'b1, 32'h0000_1003, 32'h0000_00A5, 2'b00, 1'b0, 0,     0,     0,  32'h0,        4'b1000, 32'hA5A5_A5A5, 32'h0,        1'b0, 1'b0};
      tbl[1]  = '{1'b0, 32'h0000_2002, 32'h0,        2'b01, 1'b0, 0,     0,     0,  32'h8001_1234, 4'b1100, 32'h0,        32'hFFFF_8001, 1'b0, 1'b0};
      tbl[2]  = '{1'b0, 32'h0000_2002, 32'h0,        2'b01, 1'b1, 0,     0,     0,  32'h8001_1234, 4'b1100, 32'h0,        32'h0000_8001, 1'b0, 1'b0};
      tbl[3]  = '{1'b0, 32'h0000_3001, 32'h0,        2'b11, 1'b0, 0,     0,     0,  32'h0,        4'b0000, 32'h0,        32'h0,        1'b1, 1'b0};
      tbl[4]  = '{1'b1, 32'h0000_0010, 32'h1234_ABCD, 2'b01, 1'b0, 5,     0,     3,  32'h0,        4'b0011, 32'hABCD_ABCD, 32'h0,        1'b0, 1'b0};
      tbl[5]  = '{1'b0, 32'h0000_2002, 32'h0,        2'b01, 1'b0, 5,     2,     3,  32'h8001_1234, 4'b1100, 32'h0,        32'hFFFF_8001, 1'b0, 1'b0};
      tbl[6]  = '{1'b0, 32'h0000_0101, 32'h0,        2'b00, 1'b0, 0,     0,     0,  32'h1234_7F56, 4'b0010, 32'h0,        32'h0000_007F, 1'b0, 1'b0};
      tbl[7]  = '{1'b0, 32'h0000_0102, 32'h0,        2'b00, 1'b0, 1,     1,     1,  32'h1280_7F56, 4'b0100, 32'h0,        32'hFFFF_FF80, 1'b0, 1'b0};
      tbl[8]  = '{1'b1, 32'h0000_0020, 32'h1,        2'b10, 1'b0, 0,     0,     0,  32'h0,        4'b0000, 32'h0,        32'h0,        1'b1, 1'b0};
      tbl[9]  = '{1'b1, 32'h0000_0040, 32'hDEAD_BEEF, 2'b11, 1'b0, 0,     0,     0,  32'h0,        4'b1111, 32'hDEAD_BEEF, 32'h0,        1'b0, 1'b0};
      tbl[10] = '{1'b0, 32'h0000_0500, 32'h0,        2'b11, 1'b0, 0,     NEVER, 0,  32'h0,        4'b1111, 32'h0,        32'h0,        1'b1, 1'b1};
      tbl[11] = '{1'b1, 32'h0000_0603, 32'h77,       2'b00, 1'b0, NEVER, 0,     1,  32'h0,        4'b1000, 32'h7777_7777, 32'h0,        1'b1, 1'b1};

      rst = 1'b1;
      in_valid = 1'b0; in_is_store = 1'b0; in_addr = '0; in_wdata = '0;
      in_size = 2'b00; in_unsigned = 1'b0;
      mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0; out_ready = 1'b0;
      repeat (2) @(negedge clk);

      chk("rst_in_ready", in_ready, 1);
      chk("rst_mem_req", mem_req, 0);
      chk("rst_mem_we", mem_we, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_be", mem_be, 0);
      chk("rst_mem_wdata", mem_wdata, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_rdata", out_rdata, 0);
      chk("rst_out_err", out_err, 0);
      chk("rst_out_err_timeout", out_err_timeout, 0);
      rst = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 12; i++) run_access(tbl[i]);

      // Stray grant/rvalid while idle must not start or complete anything.
      mem_rvalid = 1'b1; mem_gnt = 1'b1; mem_rdata = 32'hCAFE_F00D;
      @(negedge clk);
      mem_rvalid = 1'b0; mem_gnt = 1'b0;
      @(negedge clk);
      chk("stray_out_valid", out_valid, 0);
      chk("stray_mem_req", mem_req, 0);
      chk("stray_in_ready", in_ready, 1);

      // Reset pulse while a load waits for rvalid.
      in_valid = 1'b1; in_is_store = 1'b0; in_addr = 32'h0000_4000;
      in_size = 2'b11; in_unsigned = 1'b0;
      @(negedge clk);
      in_valid = 1'b0;
      mem_gnt  = 1'b1;
      @(negedge clk);
      mem_gnt = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("midrst_mem_req", mem_req, 0);
      chk("midrst_out_valid", out_valid, 0);
      chk("midrst_in_ready", in_ready, 1);
      rv = '{1'b0, 32'h0000_4000, 32'h0, 2'b11, 1'b0, 0, 0, 0, 32'hDEAD_BEEF,
             4'b1111, 32'h0, 32'hDEAD_BEEF, 1'b0, 1'b0};
      run_access(rv);

      // Randomized accesses against the reference model.
      for (int i = 0; i < 150; i++) begin
         logic mis, to;
         rv.st   = 1'($urandom);
         rv.a    = $urandom;
         rv.wd   = $urandom;
         rv.sz   = 2'($urandom_range(0, 3));
         rv.uns  = 1'($urandom);
         rv.gd   = ($urandom_range(0, 24) == 0) ? NEVER : $urandom_range(0, 3);
         rv.rvd  = ($urandom_range(0, 24) == 0) ? NEVER : $urandom_range(0, 3);
         rv.rdyd = $urandom_range(0, 2);
         rv.rd   = $urandom;
         mis     = is_misaligned(rv.a, rv.sz);
         to      = !mis && (rv.gd == NEVER || (!rv.st && rv.rvd == NEVER));
         rv.be   = mis ? 4'd0 : model_be(rv.a, rv.sz);
         rv.mwd  = mis ? 32'd0 : model_wdata(rv.wd, rv.sz);
         rv.exp_err = mis || to;
         rv.exp_to  = to;
         rv.exp_rd  = (mis || to || rv.st) ? 32'd0 : model_load(rv.rd, rv.a, rv.sz, rv.uns);
         run_access(rv);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
`default_nettype wire

// File: doc/risc_lsu.md
Name: risc_lsu

Overview:
- Load/store unit for the RV32I core, in the memory stage directly downstream of execute.
- Takes one load/store per handshake (address, store data, access size, signedness) and runs a single-outstanding request/grant/rvalid transaction on the data-memory port.
- Returns aligned, sign/zero-extended load data, or a store completion, to writeback.
- Detects misaligned accesses and memory timeouts.

Parameters:
- TIMEOUT_CYCLES, 16: max cycles waiting for mem_gnt or mem_rvalid before error completion; must be >= 2.

Ports:
- clk  in  1  core clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  execute presents an access
- in_ready  out  1  LSU can accept (IDLE only)
- in_is_store  in  1  1=store, 0=load
- in_addr  in  32  byte address
- in_wdata  in  32  store data (low bits used for byte/half)
- in_size  in  2  mem_size_t: 00 byte, 01 half, 11 word, 10 illegal
- in_unsigned  in  1  zero-extend load (funct3[2])
- mem_req  out  1  memory request, held until grant
- mem_we  out  1  write enable
- mem_addr  out  32  word address, bits [1:0] forced 0
- mem_be  out  4  byte enables
- mem_wdata  out  32  lane-replicated store data
- mem_gnt  in  1  request accepted this cycle
- mem_rvalid  in  1  load data valid
- mem_rdata  in  32  load data word
- out_valid  out  1  result/completion available
- out_ready  in  1  writeback consumes result
- out_rdata  out  32  extended load data (0 for stores)
- out_err  out  1  misaligned/illegal/timeout
- out_err_timeout  out  1  error cause is timeout

Behaviour:
- Reset: every output 0 except in_ready=1; FSM=IDLE; timeout counter=0. Reset mid-transaction aborts it. mem_rvalid/mem_gnt seen in IDLE are ignored.
- FSM states: IDLE, REQ, WAIT, RESP.
- IDLE (in_ready=1): on in_valid, capture all inputs.
  - If misaligned (half with addr[0]=1, word with addr[1:0]!=0, or size=10): go to RESP with out_err=1, no memory access.
  - Otherwise go to REQ.
- REQ: mem_req=1 and mem_we/mem_addr/mem_be/mem_wdata stable until mem_gnt.
  - On gnt: store goes to RESP; load goes to WAIT.
- WAIT: on mem_rvalid, register extracted data and go to RESP.
- Timeout: counter clears on each state entry and increments each cycle in REQ/WAIT. Reaching TIMEOUT_CYCLES-1 without the awaited event: mem_req drops, go to RESP with out_err=1, out_err_timeout=1.
- RESP: out_valid=1 with stable data until out_ready, then IDLE. in_ready stays 0 during RESP, including the out_ready cycle (no back-to-back accept).
- Latency with zero-wait memory (gnt in first REQ cycle, rvalid the next cycle), counting accept as cycle 0:
  - store: mem_req cycle 1, out_valid cycle 2.
  - load: mem_req 1, rvalid 2, out_valid 3.
  - misaligned: out_valid cycle 1.
- Byte enables:
  - byte: 0001<<addr[1:0].
  - half: 0011 if addr[1]=0, else 1100.
  - word: 1111.
- Store data:
  - byte: {4{wdata[7:0]}}.
  - half: {2{wdata[15:0]}}.
  - word: wdata.
- Load extract:
  - byte: rdata[8*addr[1:0]+:8].
  - half: rdata[16*addr[1]+:16].
  - Sign-extend unless in_unsigned, then zero-extend. Word is passed through and ignores in_unsigned.
- mem_we=in_is_store; mem_addr={addr[31:2],2'b00}.
- out_rdata is 0 for stores and error completions.

Test Plan:
- Store byte: addr=0x1003, wdata=0x000000A5, gnt immediate -> cycle 1 mem_be=1000, mem_wdata=0xA5A5A5A5, mem_addr=0x1000; out_valid cycle 2, out_err=0.
- Load half signed/unsigned: addr=0x2002, rdata=0x8001_1234 -> signed out_rdata=0xFFFF8001; unsigned 0x00008001; out_valid cycle 3.
- Misaligned word: addr=0x3001, size=11 -> mem_req never asserted; out_valid cycle 1, out_err=1, out_err_timeout=0.
- Grant stall plus out_ready backpressure: gnt withheld 5 cycles -> mem_req and payload stable throughout. out_ready low 3 cycles -> out_valid and out_rdata held; in_ready=0 until the cycle after the out_ready handshake.
- Timeout: load granted, rvalid never arrives, TIMEOUT_CYCLES=16 -> out_valid with out_err=1, out_err_timeout=1; a later stray rvalid in IDLE is ignored.
- Reset mid-WAIT: rst pulsed for 1 cycle -> next cycle mem_req=0, out_valid=0, in_ready=1; a subsequent word load at 0x4000 with rdata=0xDEADBEEF returns out_rdata=0xDEADBEEF.
